// File: rtl/game_pkg.sv
// Constants and types shared by the player input stage, the physics engine
// and the sprite renderer.
package game_pkg;

    localparam int STATE_W    = 3;
    localparam int SPRITE_Y_W = 7;

    localparam logic [SPRITE_Y_W-1:0] FLOOR_Y = 7'd48;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PUNCH    = 3'd1,
        ST_KICK     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_HITSTUN  = 3'd4
    } action_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/player_action_ctrl_if.sv
// Per-player bundle between the buttons/hit detection and the physics engine.
// The master side drives buttons, tick, sprite_y and hit_taken.
interface player_action_ctrl_if;
    import game_pkg::*;

    logic                  tick;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_up;
    logic                  btn_punch;
    logic                  btn_kick;
    logic [SPRITE_Y_W-1:0] sprite_y;
    logic                  hit_taken;

    logic                  moving_left;
    logic                  moving_right;
    logic                  is_jumping;
    logic                  punch_active;
    logic                  kick_active;
    logic                  stunned;
    logic [STATE_W-1:0]    action_state;

    modport master (
        output tick, btn_left, btn_right, btn_up, btn_punch, btn_kick, sprite_y, hit_taken,
        input  moving_left, moving_right, is_jumping, punch_active, kick_active, stunned,
               action_state
    );

    modport slave (
        input  tick, btn_left, btn_right, btn_up, btn_punch, btn_kick, sprite_y, hit_taken,
        output moving_left, moving_right, is_jumping, punch_active, kick_active, stunned,
               action_state
    );

endinterface

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, tick-rate debounce counter, stable level.
// level_next/rise show the value the stable level takes on this tick.
module button_debounce #(
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic level_next,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE_TICKS)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // stable_q still holds the previous tick's level while tick is high
    assign level_next = stable_d;
    assign rise       = tick & stable_d & ~stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player input stage: debounced movement/jump requests plus an
// attack/hitstun state machine, all advancing only on the game tick.
module player_action_ctrl #(
    parameter int         DEBOUNCE_TICKS = 2,
    parameter int         PUNCH_TICKS    = 4,
    parameter int         KICK_TICKS     = 6,
    parameter int         COOLDOWN_TICKS = 3,
    parameter int         HITSTUN_TICKS  = 8,
    parameter logic [6:0] FLOOR_Y        = game_pkg::FLOOR_Y
) (
    input  logic                 clk,
    input  logic                 reset,
    player_action_ctrl_if.slave  bus
);
    import game_pkg::*;

    localparam int MAX_TICKS = max4(PUNCH_TICKS, KICK_TICKS, COOLDOWN_TICKS, HITSTUN_TICKS);
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    logic left_lvl, left_rise;
    logic right_lvl, right_rise;
    logic up_lvl, up_rise;
    logic punch_lvl, punch_rise;
    logic kick_lvl, kick_rise;

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_left (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn_raw(bus.btn_left),
        .level_next(left_lvl), .rise(left_rise)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_right (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn_raw(bus.btn_right),
        .level_next(right_lvl), .rise(right_rise)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn_raw(bus.btn_up),
        .level_next(up_lvl), .rise(up_rise)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_punch (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn_raw(bus.btn_punch),
        .level_next(punch_lvl), .rise(punch_rise)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_kick (
        .clk(clk), .reset(reset), .tick(bus.tick), .btn_raw(bus.btn_kick),
        .level_next(kick_lvl), .rise(kick_rise)
    );

    action_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_pending_q, hit_pending_d;
    logic             moving_left_q, moving_left_d;
    logic             moving_right_q, moving_right_d;
    logic             is_jumping_q, is_jumping_d;
    logic             punch_active_q, punch_active_d;
    logic             kick_active_q, kick_active_d;
    logic             stunned_q, stunned_d;

    logic hit_now;
    logic grounded;
    logic free_move;

    // A hit arriving on the tick clk itself is consumed by that tick
    assign hit_now  = hit_pending_q | bus.hit_taken;
    assign grounded = (bus.sprite_y == FLOOR_Y);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hit_pending_d  = hit_pending_q | bus.hit_taken;
        moving_left_d  = moving_left_q;
        moving_right_d = moving_right_q;
        is_jumping_d   = is_jumping_q;
        punch_active_d = punch_active_q;
        kick_active_d  = kick_active_q;
        stunned_d      = stunned_q;
        free_move      = 1'b0;

        if (bus.tick) begin
            hit_pending_d = 1'b0;
            case (state_q)
                ST_IDLE, ST_COOLDOWN: begin
                    if (hit_now) begin
                        state_d = ST_HITSTUN;
                        cnt_d   = CNT_W'(HITSTUN_TICKS);
                    end else if (state_q == ST_IDLE && punch_rise) begin
                        state_d = ST_PUNCH;
                        cnt_d   = CNT_W'(PUNCH_TICKS);
                    end else if (state_q == ST_IDLE && kick_rise) begin
                        state_d = ST_KICK;
                        cnt_d   = CNT_W'(KICK_TICKS);
                    end else if (state_q == ST_COOLDOWN) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                ST_PUNCH, ST_KICK: begin
                    if (hit_now) begin
                        state_d = ST_HITSTUN;
                        cnt_d   = CNT_W'(HITSTUN_TICKS);
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = CNT_W'(COOLDOWN_TICKS);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HITSTUN: begin
                    if (hit_now) begin
                        cnt_d = CNT_W'(HITSTUN_TICKS);
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Walking and jumping only exist in the states that allow them
            free_move      = (state_d == ST_IDLE) || (state_d == ST_COOLDOWN);
            moving_left_d  = free_move & left_lvl & ~right_lvl;
            moving_right_d = free_move & right_lvl & ~left_lvl;
            is_jumping_d   = free_move & up_rise & grounded;
            punch_active_d = (state_d == ST_PUNCH);
            kick_active_d  = (state_d == ST_KICK);
            stunned_d      = (state_d == ST_HITSTUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            hit_pending_q  <= 1'b0;
            moving_left_q  <= 1'b0;
            moving_right_q <= 1'b0;
            is_jumping_q   <= 1'b0;
            punch_active_q <= 1'b0;
            kick_active_q  <= 1'b0;
            stunned_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hit_pending_q  <= hit_pending_d;
            moving_left_q  <= moving_left_d;
            moving_right_q <= moving_right_d;
            is_jumping_q   <= is_jumping_d;
            punch_active_q <= punch_active_d;
            kick_active_q  <= kick_active_d;
            stunned_q      <= stunned_d;
        end
    end

    assign bus.moving_left  = moving_left_q;
    assign bus.moving_right = moving_right_q;
    assign bus.is_jumping   = is_jumping_q;
    assign bus.punch_active = punch_active_q;
    assign bus.kick_active  = kick_active_q;
    assign bus.stunned      = stunned_q;
    assign bus.action_state = state_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl: movement, jump, attack timing,
// hitstun extension and reset abort, with hand-computed expectations.
module tb_player_action_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    player_action_ctrl_if bus();

    player_action_ctrl #(
        .DEBOUNCE_TICKS(2),
        .PUNCH_TICKS(4),
        .KICK_TICKS(6),
        .COOLDOWN_TICKS(3),
        .HITSTUN_TICKS(8),
        .FLOOR_Y(7'd48)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic check_output(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Three idle clks let a freshly driven button clear the synchronizer
    task automatic apply_tick(input logic with_hit);
        repeat (3) @(negedge clk);
        bus.tick      = 1'b1;
        bus.hit_taken = with_hit;
        @(negedge clk);
        bus.tick      = 1'b0;
        bus.hit_taken = 1'b0;
    endtask

    task automatic pulse_hit();
        bus.hit_taken = 1'b1;
        @(negedge clk);
        bus.hit_taken = 1'b0;
    endtask

    task automatic check_all_zero(input string prefix);
        check_output({prefix, "_left"},  int'(bus.moving_left),  0);
        check_output({prefix, "_right"}, int'(bus.moving_right), 0);
        check_output({prefix, "_jump"},  int'(bus.is_jumping),   0);
        check_output({prefix, "_punch"}, int'(bus.punch_active), 0);
        check_output({prefix, "_kick"},  int'(bus.kick_active),  0);
        check_output({prefix, "_stun"},  int'(bus.stunned),      0);
        check_output({prefix, "_state"}, int'(bus.action_state), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.tick      = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_punch = 1'b0;
        bus.btn_kick  = 1'b0;
        bus.hit_taken = 1'b0;
        bus.sprite_y  = 7'd48;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check_all_zero("rst");

        $display("[TB] walk right");
        bus.btn_right = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("right_mr_t%0d", t), int'(bus.moving_right), (t >= 2) ? 1 : 0);
            check_output($sformatf("right_ml_t%0d", t), int'(bus.moving_left), 0);
        end

        $display("[TB] left and right together");
        bus.btn_left = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("both_mr_t%0d", t), int'(bus.moving_right), (t == 1) ? 1 : 0);
            check_output($sformatf("both_ml_t%0d", t), int'(bus.moving_left), 0);
        end
        bus.btn_right = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("relr_ml_t%0d", t), int'(bus.moving_left), (t == 2) ? 1 : 0);
            check_output($sformatf("relr_mr_t%0d", t), int'(bus.moving_right), 0);
        end
        bus.btn_left = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("rell_ml_t%0d", t), int'(bus.moving_left), (t == 1) ? 1 : 0);
        end

        $display("[TB] jump grounded then airborne");
        bus.btn_up = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("jump_gnd_t%0d", t), int'(bus.is_jumping), (t == 2) ? 1 : 0);
        end
        bus.btn_up = 1'b0;
        repeat (3) apply_tick(1'b0);
        bus.sprite_y = 7'd30;
        bus.btn_up   = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("jump_air_t%0d", t), int'(bus.is_jumping), 0);
        end
        bus.btn_up = 1'b0;
        repeat (3) apply_tick(1'b0);
        bus.sprite_y = 7'd48;

        $display("[TB] punch, cooldown, ignored kick");
        bus.btn_punch = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("pch_state_t%0d", t), int'(bus.action_state),
                         (t >= 2 && t <= 5) ? 1 : ((t >= 6 && t <= 8) ? 3 : 0));
            check_output($sformatf("pch_active_t%0d", t), int'(bus.punch_active),
                         (t >= 2 && t <= 5) ? 1 : 0);
            check_output($sformatf("pch_kick_t%0d", t), int'(bus.kick_active), 0);
            if (t == 2) bus.btn_punch = 1'b0;
            if (t == 5) bus.btn_kick = 1'b1;
        end
        bus.btn_kick = 1'b0;
        repeat (2) apply_tick(1'b0);
        check_output("post_cool_state", int'(bus.action_state), 0);

        $display("[TB] kick interrupted by hit, hitstun extended");
        bus.btn_kick = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("kick_active_t%0d", t), int'(bus.kick_active), (t >= 2) ? 1 : 0);
            check_output($sformatf("kick_state_t%0d", t), int'(bus.action_state), (t >= 2) ? 2 : 0);
            if (t == 2) bus.btn_kick = 1'b0;
        end
        @(negedge clk);
        pulse_hit();
        for (int s = 1; s <= 13; s++) begin
            if (s == 5) pulse_hit();
            apply_tick(1'b0);
            check_output($sformatf("stun_s%0d", s), int'(bus.stunned), (s <= 12) ? 1 : 0);
            check_output($sformatf("stun_state_s%0d", s), int'(bus.action_state), (s <= 12) ? 4 : 0);
            check_output($sformatf("stun_kick_s%0d", s), int'(bus.kick_active), 0);
        end

        $display("[TB] hit aligned with tick");
        apply_tick(1'b1);
        check_output("hit_align_stun_t1", int'(bus.stunned), 1);
        for (int t = 2; t <= 9; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("hit_align_stun_t%0d", t), int'(bus.stunned), (t <= 8) ? 1 : 0);
        end

        $display("[TB] reset during punch");
        bus.btn_punch = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("rstp_active_t%0d", t), int'(bus.punch_active), (t >= 2) ? 1 : 0);
        end
        bus.btn_punch = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_punch");
        @(negedge clk);
        reset = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            apply_tick(1'b0);
            check_output($sformatf("after_rst_state_t%0d", t), int'(bus.action_state), 0);
            check_output($sformatf("after_rst_punch_t%0d", t), int'(bus.punch_active), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
